// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: serialized single-port byte memory controller.
// Requests are accepted only in IDLE; operands are latched so the
// requester may change its buses while the access is in flight.
// Optional macro DM_ADDR_CHECK_EN: flag (and suppress) accesses whose
// latched address is >= DEPTH instead of wrapping modulo DEPTH.
module data_mem_ctrl #(
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic              MEM_REQ,
  input  logic [1:0]        MEM_OP,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [7:0]        dm_data,
  output logic [7:0]        mem_data,
  output logic              MEM_BUSY,
  output logic              MEM_DONE,
  output logic              MEM_ERR
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = 2;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b11;

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              we;
  logic              addr_bad;
  logic [AW-1:0]     idx;

  // Storage is deliberately not reset so contents survive RST_N.
  logic [7:0] mem [DEPTH];

  assign idx = addr_q[AW-1:0];

`ifdef DM_ADDR_CHECK_EN
  assign addr_bad = (addr_q >= ADDR_W'(DEPTH));
`else
  // Upper address bits are dropped: addresses wrap modulo DEPTH.
  logic unused_addr_hi;
  assign addr_bad       = 1'b0;
  assign unused_addr_hi = ^addr_q[ADDR_W-1:AW];
`endif

  // Next-state, operand latching and completion flags.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_REQ) begin
          if (MEM_OP == OP_WR) begin
            addr_d  = dm_addr;
            wdata_d = dm_data;
            state_d = WRITE;
          end else if (MEM_OP == OP_RD) begin
            addr_d  = dm_addr;
            cnt_d   = CNT_W'(RD_LAT - 1);
            state_d = READ_WAIT;
          end
        end
      end
      WRITE: begin
        we      = !addr_bad;
        done_d  = 1'b1;
        err_d   = addr_bad;
        state_d = DONE;
      end
      READ_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = addr_bad ? 8'h00 : mem[idx];
          done_d  = 1'b1;
          err_d   = addr_bad;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Array write; we is only raised from WRITE, so reset blocks it.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata_q;
  end

  assign mem_data = rdata_q;
  assign MEM_BUSY = (state_q != IDLE);
  assign MEM_DONE = done_q;
  assign MEM_ERR  = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: vector table with a scoreboard queue,
// plus hand-written sequences for no-op codes, held requests and reset.
module tb_data_mem_ctrl;

  localparam int ADDR_W = 19;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
`ifdef DM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              RST_N = 1'b0;
  logic              MEM_REQ = 1'b0;
  logic [1:0]        MEM_OP = 2'b00;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [7:0]        dm_data = '0;
  logic [7:0]        mem_data;
  logic              MEM_BUSY, MEM_DONE, MEM_ERR;

  int checks = 0;
  int failures = 0;
  logic [7:0] last_rd = 8'h00;

  typedef struct {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic [7:0]        exp_rd;
    logic              exp_err;
  } vec_t;

  typedef struct {
    logic       is_rd;
    logic [7:0] rd;
    logic       err;
    int         lat;
  } exp_t;

  vec_t vecs[11];
  exp_t sbq[$];

  data_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .RST_N(RST_N), .MEM_REQ(MEM_REQ), .MEM_OP(MEM_OP),
    .dm_addr(dm_addr), .dm_data(dm_data), .mem_data(mem_data),
    .MEM_BUSY(MEM_BUSY), .MEM_DONE(MEM_DONE), .MEM_ERR(MEM_ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete request through the scoreboard; returns once back in IDLE.
  task automatic run_req(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] data, input logic [7:0] exp_rd,
                         input logic exp_err);
    exp_t e;
    exp_t g;
    int   n;
    bit   seen;
    @(negedge clk);
    chk("idle_before_req", MEM_BUSY, 0);
    e.is_rd = (op == 2'b11);
    e.rd    = e.is_rd ? exp_rd : last_rd;
    e.err   = exp_err;
    e.lat   = e.is_rd ? RD_LAT + 1 : 2;
    sbq.push_back(e);
    MEM_REQ = 1'b1; MEM_OP = op; dm_addr = addr; dm_data = data;
    @(posedge clk);
    #1;
    MEM_REQ = 1'b0; dm_addr = ~addr; dm_data = ~data;
    n = 0; seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (MEM_DONE) seen = 1'b1;
      else chk("busy_in_flight", MEM_BUSY, 1);
    end
    g = sbq.pop_front();
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("latency", n, g.lat);
      chk("err_flag", MEM_ERR, g.err);
      chk("mem_data", mem_data, g.rd);
      chk("busy_with_done", MEM_BUSY, 1);
      if (g.is_rd) last_rd = g.rd;
    end
    @(negedge clk);
    chk("done_one_cycle", MEM_DONE, 0);
    chk("busy_low_after", MEM_BUSY, 0);
    chk("err_low_after", MEM_ERR, 0);
  endtask

  initial begin
    int n;
    bit seen;
    vecs[0]  = '{2'b01, 19'd5,    8'hA5, 8'h00, 1'b0};
    vecs[1]  = '{2'b11, 19'd5,    8'h00, 8'hA5, 1'b0};
    vecs[2]  = '{2'b01, 19'd0,    8'h11, 8'h00, 1'b0};
    vecs[3]  = '{2'b01, 19'd1023, 8'hEE, 8'h00, 1'b0};
    vecs[4]  = '{2'b11, 19'd0,    8'h00, 8'h11, 1'b0};
    vecs[5]  = '{2'b11, 19'd1023, 8'h00, 8'hEE, 1'b0};
    vecs[6]  = '{2'b01, 19'd1024, 8'h3C, 8'h00, CHK};
    vecs[7]  = '{2'b11, 19'd0,    8'h00, (CHK ? 8'h11 : 8'h3C), 1'b0};
    vecs[8]  = '{2'b11, 19'd1024, 8'h00, (CHK ? 8'h00 : 8'h3C), CHK};
    vecs[9]  = '{2'b01, 19'd7,    8'h77, 8'h00, 1'b0};
    vecs[10] = '{2'b11, 19'd7,    8'h00, 8'h77, 1'b0};

    // Reset state
    #1;
    chk("rst_busy", MEM_BUSY, 0);
    chk("rst_done", MEM_DONE, 0);
    chk("rst_err", MEM_ERR, 0);
    chk("rst_mem_data", mem_data, 8'h00);
    repeat (2) @(negedge clk);
    RST_N = 1'b1;

    // Undefined op codes are ignored
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      MEM_REQ = 1'b1; MEM_OP = (c == 0) ? 2'b10 : 2'b00; dm_addr = 19'd5;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("noop_busy", MEM_BUSY, 0);
        chk("noop_done", MEM_DONE, 0);
      end
      MEM_REQ = 1'b0;
    end

    // Vector table
    for (int i = 0; i < 11; i++)
      run_req(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp_rd, vecs[i].exp_err);

    // Request held high, address changed during READ_WAIT
    @(negedge clk);
    MEM_REQ = 1'b1; MEM_OP = 2'b11; dm_addr = 19'd5;
    @(posedge clk);
    #1 dm_addr = 19'd1023;
    n = 0; seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk); n++;
      if (MEM_DONE) seen = 1'b1;
    end
    chk("held_seen1", seen, 1);
    chk("held_lat1", n, RD_LAT + 1);
    chk("held_data1", mem_data, 8'hA5);
    @(negedge clk);
    chk("held_idle_gap_busy", MEM_BUSY, 0);
    chk("held_idle_gap_done", MEM_DONE, 0);
    n = 0; seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk); n++;
      if (MEM_DONE) seen = 1'b1;
    end
    MEM_REQ = 1'b0;
    chk("held_seen2", seen, 1);
    chk("held_lat2", n, RD_LAT + 1);
    chk("held_data2", mem_data, 8'hEE);
    last_rd = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("held_no_extra_done", MEM_DONE, 0);
    end

    // Reset during READ_WAIT
    @(negedge clk);
    MEM_REQ = 1'b1; MEM_OP = 2'b11; dm_addr = 19'd5;
    @(posedge clk);
    #1 MEM_REQ = 1'b0;
    @(negedge clk);
    chk("rw_busy_before_rst", MEM_BUSY, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("rw_rst_busy", MEM_BUSY, 0);
    chk("rw_rst_done", MEM_DONE, 0);
    chk("rw_rst_err", MEM_ERR, 0);
    chk("rw_rst_mem_data", mem_data, 8'h00);
    @(negedge clk);
    RST_N = 1'b1;
    last_rd = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rw_no_done_after_rst", MEM_DONE, 0);
    end
    run_req(2'b11, 19'd5, 8'h00, 8'hA5, 1'b0);

    // Reset during WRITE aborts the store
    @(negedge clk);
    MEM_REQ = 1'b1; MEM_OP = 2'b01; dm_addr = 19'd7; dm_data = 8'h99;
    @(posedge clk);
    #1 MEM_REQ = 1'b0;
    #2 RST_N = 1'b0;
    #1 chk("wr_rst_busy", MEM_BUSY, 0);
    @(negedge clk);
    RST_N = 1'b1;
    last_rd = 8'h00;
    run_req(2'b11, 19'd7, 8'h00, 8'h77, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 19, meaning the address width in bits; the value SHALL match the register-file dm_addr bus.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning the number of 8-bit words stored; the value SHALL be a power of two.
REQ-003 The block SHALL have parameter RD_LAT, default 2, meaning the read latency in cycles; legal values SHALL be 1 to 4.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port MEM_REQ, input, 1 bit: request strobe, sampled only in IDLE.
REQ-007 The block SHALL have port MEM_OP, input, 2 bits, with the encoding 2'b01 = write and 2'b11 = read; all other codes SHALL be no-ops.
REQ-008 The block SHALL have port dm_addr, input, ADDR_W bits: access address.
REQ-009 The block SHALL have port dm_data, input, 8 bits: write data.
REQ-010 The block SHALL have port mem_data, output, 8 bits: read data returned to the register file.
REQ-011 The block SHALL have port MEM_BUSY, output, 1 bit: high while a request is in flight.
REQ-012 The block SHALL have port MEM_DONE, output, 1 bit: a one-cycle completion pulse.
REQ-013 The block SHALL have port MEM_ERR, output, 1 bit: out-of-range flag, valid with MEM_DONE.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, WRITE, READ_WAIT and DONE.
REQ-015 In IDLE, MEM_REQ=1 with MEM_OP=01 at edge k SHALL latch dm_addr, dm_data and the op, and SHALL enter WRITE.
REQ-016 In IDLE, MEM_REQ=1 with MEM_OP=11 SHALL latch dm_addr, load the latency counter with RD_LAT-1, and enter READ_WAIT.
REQ-017 In IDLE, MEM_REQ=1 with MEM_OP=00 or 10 SHALL be ignored: state SHALL stay IDLE and no DONE SHALL be issued.
REQ-018 WRITE SHALL store the latched data at index addr[log2(DEPTH)-1:0], then go to DONE; MEM_DONE SHALL be high in the cycle after edge k+2.
REQ-019 READ_WAIT SHALL decrement the counter each cycle.
REQ-020 At counter zero, READ_WAIT SHALL load mem_data from the array and go to DONE; mem_data SHALL be valid no later than the cycle in which MEM_DONE is high, i.e. edge k+RD_LAT+1.
REQ-021 DONE SHALL assert MEM_DONE for exactly one cycle and then return to IDLE; a new request SHALL be accepted no earlier than the first IDLE cycle.
REQ-022 MEM_BUSY SHALL be 1 in WRITE, READ_WAIT and DONE, and 0 in IDLE.
REQ-023 MEM_REQ and changes to dm_addr or dm_data while MEM_BUSY=1 SHALL have no effect, because the operands are latched.
REQ-024 mem_data SHALL hold the last read value until the next read completes; writes SHALL NOT change mem_data.
REQ-025 A read of an address written earlier SHALL return the written value; no read-during-write hazard exists because accesses are serialized.

Reset
REQ-026 RST_N=0 SHALL force, asynchronously: state IDLE, mem_data=8'h00, MEM_BUSY=0, MEM_DONE=0, MEM_ERR=0, latched operands 0 and counter 0.
REQ-027 Reset SHALL NOT clear the storage array.
REQ-028 Reset asserted mid-operation SHALL abort the operation: no DONE pulse SHALL follow, and an aborted WRITE that has not reached its edge SHALL leave memory unchanged.
REQ-029 After RST_N rises, the first request SHALL be accepted at the next rising edge.

Configuration
REQ-030 The macro DM_ADDR_CHECK_EN SHALL control out-of-range checking.
REQ-031 When DM_ADDR_CHECK_EN is defined, a latched address >= DEPTH SHALL suppress the write, return mem_data=8'h00 on a read, and assert MEM_ERR=1 together with MEM_DONE for one cycle; otherwise MEM_ERR SHALL be 0.
REQ-032 When DM_ADDR_CHECK_EN is undefined, addresses SHALL wrap modulo DEPTH and MEM_ERR SHALL be tied to 0.

Verification
REQ-033 The bench SHALL cover: write 8'hA5 to address 5, then read address 5 with RD_LAT=2 -> MEM_DONE 2 cycles after the write request, mem_data=8'hA5 with MEM_DONE 3 cycles after the read request.
REQ-034 The bench SHALL cover: MEM_REQ held high with dm_addr changed during READ_WAIT -> data from the originally latched address, exactly one DONE pulse, and acceptance resuming only in IDLE.
REQ-035 The bench SHALL cover: MEM_OP=2'b10 with MEM_REQ=1 -> MEM_BUSY stays 0 and no MEM_DONE.
REQ-036 The bench SHALL cover: RST_N low during READ_WAIT -> outputs 0 immediately, no DONE, and previously written data still readable after reset.
REQ-037 The bench SHALL cover: write 8'h3C to address 1024 with DEPTH=1024 -> with DM_ADDR_CHECK_EN, MEM_ERR=1 and address 0 unchanged; without it, address 0 reads 8'h3C.
REQ-038 The bench SHALL cover: back-to-back reads to addresses 0 and DEPTH-1 -> correct data and MEM_BUSY low for at least one cycle between requests.
